// File: rtl/sirv_clint_rtc_gen.sv
// ICB-programmable prescaler that flips io_rtcToggle every DIV+1 clocks; responses arrive one cycle after handshake and hold until rsp_ready.
// Optional flip counter TCNT at offset 0x8 is built only when SIRV_RTC_GEN_TCNT_EN is defined.
module sirv_clint_rtc_gen #(
    parameter int unsigned      DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(99)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_icb_cmd_valid,
    output logic        i_icb_cmd_ready,
    input  logic [31:0] i_icb_cmd_addr,
    input  logic        i_icb_cmd_read,
    input  logic [31:0] i_icb_cmd_wdata,
    output logic        i_icb_rsp_valid,
    input  logic        i_icb_rsp_ready,
    output logic [31:0] i_icb_rsp_rdata,
    output logic        i_icb_rsp_err,
    output logic        io_rtcToggle
);

    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tog_q, tog_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      tcnt_val;

    logic       cmd_hsk;
    logic [1:0] sel;
    logic       wr_ctrl;
    logic       wr_div;
    logic       clr;
    logic       flip;
    logic       unused_bits;

    assign i_icb_cmd_ready = ~rsp_vld_q | i_icb_rsp_ready;
    assign cmd_hsk         = i_icb_cmd_valid & i_icb_cmd_ready;
    assign sel             = i_icb_cmd_addr[3:2];
    assign wr_ctrl         = cmd_hsk & ~i_icb_cmd_read & (sel == 2'd0);
    assign wr_div          = cmd_hsk & ~i_icb_cmd_read & (sel == 2'd1);
    assign clr             = wr_ctrl & i_icb_cmd_wdata[1];
    assign unused_bits     = ^{i_icb_cmd_addr[31:4], i_icb_cmd_addr[1:0], i_icb_cmd_wdata};

    always_comb begin
        en_d  = wr_ctrl ? i_icb_cmd_wdata[0] : en_q;
        div_d = wr_div ? i_icb_cmd_wdata[DIV_W-1:0] : div_q;
        cnt_d = cnt_q;
        tog_d = tog_q;
        flip  = 1'b0;
        if (clr) begin
            cnt_d = '0;
            tog_d = 1'b0;
        end else if (!en_q) begin
            cnt_d = '0;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
            tog_d = ~tog_q;
            flip  = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // A divisor write restarts the period; a coincident flip above still uses the old DIV.
        if (wr_div) begin
            cnt_d = '0;
        end
    end

`ifdef SIRV_RTC_GEN_TCNT_EN
    logic [31:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr) begin
            tcnt_d = '0;
        end else if (flip) begin
            tcnt_d = tcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tcnt_val = tcnt_q;
`else
    assign tcnt_val = 32'd0;
`endif

    always_comb begin
        rsp_vld_d   = rsp_vld_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (cmd_hsk) begin
            rsp_vld_d   = 1'b1;
            rsp_err_d   = (sel == 2'd3);
            rsp_rdata_d = 32'd0;
            if (i_icb_cmd_read) begin
                case (sel)
                    2'd0:    rsp_rdata_d = {31'd0, en_q};
                    2'd1:    rsp_rdata_d = 32'(div_q);
                    2'd2:    rsp_rdata_d = tcnt_val;
                    default: rsp_rdata_d = 32'd0;
                endcase
            end
        end else if (i_icb_rsp_ready) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en_q        <= 1'b0;
            div_q       <= DIV_RST;
            cnt_q       <= '0;
            tog_q       <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            en_q        <= en_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            tog_q       <= tog_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign i_icb_rsp_valid = rsp_vld_q;
    assign i_icb_rsp_rdata = rsp_rdata_q;
    assign i_icb_rsp_err   = rsp_err_q;
    assign io_rtcToggle    = tog_q;

endmodule

// File: doc/sirv_clint_rtc_gen.md
# sirv_clint_rtc_gen

ICB-programmable real-time-tick generator that drives the `io_rtcToggle` input of the CLINT top. It divides the core clock by a software-set divisor and flips its output once per period. The CLINT edge-detects each flip as one `mtime` increment. The block sits on the private peripheral ICB next to the CLINT and replaces a free-running external toggle source.

## Interface
Parameters:
- `DIV_W`, default 16: width of the divisor register.
- `DIV_RST`, default 16'd99: reset value of DIV, giving a tick every 100 clocks.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_icb_cmd_valid`  in  1  command valid.
- `i_icb_cmd_ready`  out  1  command ready.
- `i_icb_cmd_addr`  in  32  byte address; only [3:2] is decoded.
- `i_icb_cmd_read`  in  1  1 = read, 0 = write.
- `i_icb_cmd_wdata`  in  32  write data.
- `i_icb_rsp_valid`  out  1  response valid.
- `i_icb_rsp_ready`  in  1  response ready.
- `i_icb_rsp_rdata`  out  32  read data; 0 on writes.
- `i_icb_rsp_err`  out  1  access to a reserved offset.
- `io_rtcToggle`  out  1  toggle output, connects to the CLINT `io_rtcToggle` input.

## Operation
Register map, by `addr[3:2]`:
- 0x0 CTRL:
  - bit0 EN, read/write, reset 0.
  - bit1 CLR, write-1 pulse, reads 0. Zeroes the prescaler counter and drives `io_rtcToggle` to 0.
  - Other bits read 0.
- 0x4 DIV: [DIV_W-1:0] read/write, reset `DIV_RST`. Upper bits read 0.
- 0x8 TCNT: 32-bit count of output flips, read-only; see Configuration. Writes are ignored with no error.
- 0xC: reserved. Reads return 0. Writes are ignored. Response has `rsp_err`=1.

Prescaler:
- Counter `cnt`, DIV_W bits, reset 0.
- While EN=1, `cnt` increments each clock. When `cnt==DIV`, `cnt` returns to 0 and `io_rtcToggle` flips.
- DIV=0 flips the output every cycle. DIV=all-ones gives period 2^DIV_W.
- While EN=0, `cnt` is held at 0 and `io_rtcToggle` holds its value.
- A write to DIV zeroes `cnt` on the same edge. If the terminal count coincides with that write, the flip still occurs, using the old DIV.
- CLR has priority over counting. A write with EN=1 and CLR=1 restarts cleanly from 0.
- TCNT increments on every flip and wraps 0xFFFF_FFFF→0. CLR zeroes TCNT.

ICB:
- Single outstanding transaction.
- `cmd_ready = ~rsp_valid_q | i_icb_rsp_ready`.
- The response register loads on command handshake.
- `rsp_valid` holds until `rsp_ready`. `rdata` and `err` are stable while valid.
- A write takes effect on the handshake edge.
- A read returns the register value sampled at the handshake edge.

Reset values: `i_icb_cmd_ready`=1, `i_icb_rsp_valid`=0, `i_icb_rsp_rdata`=0, `i_icb_rsp_err`=0, `io_rtcToggle`=0. Reset mid-transaction drops any pending response.

## Timing
- Command handshake at cycle T gives response valid at T+1. Back-to-back throughput is 1/cycle when `rsp_ready` is held high.
- EN write handshake at T:
  - EN visible and `cnt` counting from T+1.
  - First flip visible at T+DIV+2.
  - Later flips every DIV+1 cycles.
- CLINT tick rate is clock/(DIV+1). Each flip is one `mtime` increment.
- Output is a direct flop with no combinational path from the ICB to `io_rtcToggle`.

## Configuration
- `SIRV_RTC_GEN_TCNT_EN` defined: the 32-bit TCNT counter is built as described above.
- `SIRV_RTC_GEN_TCNT_EN` undefined:
  - No counter flops.
  - Offset 0x8 reads 0 and writes are ignored, with `rsp_err`=0.
  - All other behaviour is identical.

## Test plan
- Reset, no traffic → `io_rtcToggle`=0. Read DIV returns 99. Read CTRL returns 0.
- Write DIV=3, then CTRL=1 → output flips every 4 clocks. First flip 5 cycles after the CTRL handshake. TCNT reads 10 after 40 further cycles (macro on).
- Write DIV=0 while running → flip every cycle. A DIV write landing on terminal count still flips once with the old divisor, then `cnt` restarts at 0.
- Hold `rsp_ready`=0 for 5 cycles after a read → `rsp_valid` and `rdata` stable, `cmd_ready`=0. Release → next command is accepted on the same cycle.
- Access offset 0xC → `rsp_err`=1 and `rdata`=0. Write CTRL=3 → TCNT=0, output 0, counting resumes.
- Assert `reset` mid-response with EN=1 → next cycle `rsp_valid`=0, EN=0, output 0, DIV=99.
